// File: rtl/tile_flusher.sv
// tile_flusher: streams a finished tile out of the tile BRAM into the shared
// framebuffer write port, with a small credit-managed FIFO absorbing write stalls.
module tile_flusher #(
    parameter int TILE_W     = 20,
    parameter int TILE_H     = 45,
    parameter int FB_W       = 320,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [8:0]  tile_x_offset,
    input  logic [7:0]  tile_y_offset,
    output logic [9:0]  tile_bram_read_addr,
    input  logic [31:0] tile_bram_read_data,
    output logic [16:0] fb_write_addr,
    output logic [15:0] fb_write_data,
    output logic        fb_write_valid,
    input  logic        fb_write_ready,
    output logic        busy,
    output logic        done
);
    localparam int CW  = $clog2(TILE_W);
    localparam int RW  = $clog2(TILE_H);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CNW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q;
    logic [8:0]      x_off_q;
    logic [7:0]      y_off_q;
    logic [CW-1:0]   col_q, col1_q, col2_q;
    logic [RW-1:0]   row_q, row1_q, row2_q;
    logic [9:0]      rd_addr_q;
    logic            v1_q, v2_q, busy_q, done_q;
    logic [32:0]     fifo_q [FIFO_DEPTH];
    logic [PW-1:0]   wp_q, rp_q;
    logic [CNW-1:0]  cnt_q;
    logic            issue, pop, last, drained;
    logic [16:0]     fb_addr;
    logic            unused_depth;

    // Credit uses registered occupancy only, so a same-cycle pop never frees a slot early.
    assign issue   = state_q == RUN && (cnt_q + CNW'(v1_q) + CNW'(v2_q)) < CNW'(FIFO_DEPTH);
    assign pop     = fb_write_valid && fb_write_ready;
    assign last    = col_q == CW'(TILE_W - 1) && row_q == RW'(TILE_H - 1);
    assign drained = !v1_q && !v2_q && (cnt_q == CNW'(0) || (cnt_q == CNW'(1) && pop));
    assign fb_addr = (17'(y_off_q) + 17'(row2_q)) * 17'(FB_W) + 17'(x_off_q) + 17'(col2_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_off_q   <= '0;
            y_off_q   <= '0;
            col_q     <= '0;
            row_q     <= '0;
            col1_q    <= '0;
            row1_q    <= '0;
            col2_q    <= '0;
            row2_q    <= '0;
            rd_addr_q <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    x_off_q   <= tile_x_offset;
                    y_off_q   <= tile_y_offset;
                    col_q     <= '0;
                    row_q     <= '0;
                    rd_addr_q <= '0;
                    busy_q    <= 1'b1;
                    state_q   <= RUN;
                end
                RUN: if (issue) begin
                    if (last) state_q <= DRAIN;
                    else begin
                        rd_addr_q <= rd_addr_q + 10'd1;
                        col_q     <= col_q == CW'(TILE_W - 1) ? '0 : col_q + CW'(1);
                        row_q     <= col_q == CW'(TILE_W - 1) ? row_q + RW'(1) : row_q;
                    end
                end
                DRAIN: if (drained) begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
            // Position rides with the read so the returning word knows where it lands.
            v1_q   <= issue;
            col1_q <= col_q;
            row1_q <= row_q;
            v2_q   <= v1_q;
            col2_q <= col1_q;
            row2_q <= row1_q;
            if (v2_q) begin
                fifo_q[wp_q] <= {fb_addr, tile_bram_read_data[15:0]};
                wp_q         <= wp_q + PW'(1);
            end
            if (pop) rp_q <= rp_q + PW'(1);
            cnt_q <= cnt_q + CNW'(v2_q) - CNW'(pop);
        end
    end

    assign tile_bram_read_addr = rd_addr_q;
    assign fb_write_addr       = fifo_q[rp_q][32:16];
    assign fb_write_data       = fifo_q[rp_q][15:0];
    assign fb_write_valid      = cnt_q != '0;
    assign busy                = busy_q;
    assign done                = done_q;
    assign unused_depth        = ^tile_bram_read_data[31:16];
endmodule

// File: tb/tb_tile_flusher.sv
// tb_tile_flusher: scoreboard bench for tile_flusher; expected writes are queued
// at start and compared as the framebuffer port accepts them.
module tb_tile_flusher;
    logic        clk = 1'b0;
    logic        rst_n, start, fb_write_ready, fb_write_valid, busy, done;
    logic [8:0]  tile_x_offset;
    logic [7:0]  tile_y_offset;
    logic [9:0]  tile_bram_read_addr;
    logic [31:0] tile_bram_read_data;
    logic [16:0] fb_write_addr;
    logic [15:0] fb_write_data;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [32:0] exp_q[$];
    logic [15:0] salt_g = '0;
    bit          rnd_mode = 0;
    bit          stall_req = 0;
    logic [31:0] p1 = '0, p2 = '0;
    bit          stalled = 0;
    logic [16:0] held_addr;
    logic [15:0] held_data;

    tile_flusher dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .tile_x_offset(tile_x_offset), .tile_y_offset(tile_y_offset),
        .tile_bram_read_addr(tile_bram_read_addr), .tile_bram_read_data(tile_bram_read_data),
        .fb_write_addr(fb_write_addr), .fb_write_data(fb_write_data),
        .fb_write_valid(fb_write_valid), .fb_write_ready(fb_write_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Tile BRAM model: two-cycle read latency, depth field is junk the DUT must drop.
    always @(posedge clk) begin
        p1 <= {16'hA5A5 ^ {6'd0, tile_bram_read_addr}, {6'd0, tile_bram_read_addr} ^ salt_g};
        p2 <= p1;
    end
    assign tile_bram_read_data = p2;

    initial begin
        fb_write_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            fb_write_ready = rnd_mode ? 1'($urandom_range(0, 1)) : !stall_req;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (stalled && fb_write_valid) begin
            check("hold_addr", fb_write_addr, held_addr);
            check("hold_data", fb_write_data, held_data);
        end
        stalled   = fb_write_valid && !fb_write_ready;
        held_addr = fb_write_addr;
        held_data = fb_write_data;
        if (fb_write_valid && fb_write_ready) begin
            if (exp_q.size() == 0) check("extra_write", 1, 0);
            else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("wr_addr", fb_write_addr, e[32:16]);
                check("wr_data", fb_write_data, e[15:0]);
            end
        end
    end

    task automatic run_flush(input int x, input int y, input logic [15:0] salt,
                             input bit stall, input bit exact, input int rst_at, input bit poke);
        int n, acc, max_out, out;
        logic [9:0] held;
        bit got_done;
        for (int r = 0; r < 45; r++)
            for (int c = 0; c < 20; c++)
                exp_q.push_back({17'((y + r) * 320 + x + c), 16'(r * 20 + c) ^ salt});
        @(negedge clk);
        check("done_width", done, 0);
        start = 1'b1;
        tile_x_offset = 9'(x);
        tile_y_offset = 8'(y);
        salt_g = salt;
        acc = 0;
        max_out = 0;
        got_done = 0;
        held = '0;
        for (n = 1; n <= 3000 && !got_done; n++) begin
            @(negedge clk);
            start = poke && n == 100;
            if (n == 2) begin
                tile_x_offset = 9'($urandom);
                tile_y_offset = 8'($urandom);
            end
            if (n == 1) begin
                check("busy_c1", busy, 1);
                check("raddr_c1", tile_bram_read_addr, 0);
            end
            if (n == 3) check("valid_c3", fb_write_valid, 0);
            if (n == 4) check("valid_c4", fb_write_valid, 1);
            if (stall) stall_req = n >= 9 && n < 59;
            if (stall && n == 20) begin
                check("stall_raddr", tile_bram_read_addr, 10);
                held = tile_bram_read_addr;
            end
            if (stall && n == 58) check("stall_raddr_hold", tile_bram_read_addr, held);
            if (busy) begin
                out = int'(tile_bram_read_addr) - acc;
                if (out > max_out) max_out = out;
            end
            if (fb_write_valid && fb_write_ready) acc++;
            if (rst_at != 0 && n == rst_at) rst_n = 1'b0;
            if (rst_at != 0 && n == rst_at + 1) begin
                rst_n = 1'b1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_valid", fb_write_valid, 0);
                check("rst_raddr", tile_bram_read_addr, 0);
                check("rst_fbaddr", fb_write_addr, 0);
                check("rst_fbdata", fb_write_data, 0);
                exp_q.delete();
                return;
            end
            if (done) begin
                got_done = 1;
                if (exact) check("done_cycle", n, 904);
                if (poke) start = 1'b1;
            end
        end
        check("done_seen", got_done, 1);
        check("busy_at_done", busy, 0);
        check("missing_writes", exp_q.size(), 0);
        check("outstanding_le4", max_out <= 4, 1);
        if (stall) check("stall_max_outstanding", max_out, 4);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        start = 1'b0;
        tile_x_offset = '0;
        tile_y_offset = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", fb_write_valid, 0);
        check("reset_raddr", tile_bram_read_addr, 0);
        check("reset_fbaddr", fb_write_addr, 0);
        check("reset_fbdata", fb_write_data, 0);
        rst_n = 1'b1;
        run_flush(0, 0, 16'h0000, 0, 1, 0, 0);
        run_flush(300, 135, 16'h5A5A, 0, 1, 0, 0);
        rnd_mode = 1;
        run_flush(37, 90, 16'h1234, 0, 0, 0, 0);
        rnd_mode = 0;
        repeat (2) @(negedge clk);
        run_flush(100, 20, 16'h0F0F, 1, 0, 0, 0);
        run_flush(60, 45, 16'h7777, 0, 0, 200, 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || fb_write_valid) seen = 1;
        end
        check("quiet_after_reset", seen, 0);
        run_flush(60, 45, 16'h7777, 0, 1, 0, 0);
        run_flush(10, 10, 16'h3C3C, 0, 1, 0, 1);
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", done, 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || fb_write_valid) seen = 1;
        end
        check("start_on_done_ignored", seen, 0);
        run_flush(1, 2, 16'h0001, 0, 1, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
